// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter feeding a single binary-to-BCD converter.
// IDLE grants one requester, CONV registers the double-dabble result, OUT holds it until accepted.
module bcd_conv_arbiter #(
    parameter int unsigned N       = 8,
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned BCD_W  = 4 * ((N * 30103) / 100000 + 1),
    localparam int unsigned TAG_W  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*N-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BCD_W-1:0]       out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy,
    output logic [15:0]            conv_count
);

    localparam int unsigned DIGITS = BCD_W / 4;

    typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

    state_t               state;
    state_t               state_n;
    logic [TAG_W-1:0]     last_grant;
    logic [TAG_W-1:0]     grant_idx;
    logic [TAG_W-1:0]     op_tag;
    logic [N-1:0]         operand;
    logic [N-1:0]         grant_data;
    logic [NUM_REQ-1:0]   grant_oh;
    logic                 grant_found;
    logic                 armed;
    logic                 take;
    logic                 done;
    logic [BCD_W-1:0]     bcd_c;

    function automatic logic [BCD_W-1:0] to_bcd(input logic [N-1:0] bin);
        logic [BCD_W-1:0] bcd;
        bcd = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            for (int d = 0; d < int'(DIGITS); d++) begin
                if (bcd[d*4 +: 4] >= 4'd5) begin
                    bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
                end
            end
            bcd = {bcd[BCD_W-2:0], bin[i]};
        end
        return bcd;
    endfunction

    assign bcd_c = to_bcd(operand);

    // Round-robin search starting just after the previous winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        grant_data  = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!grant_found && req_valid[i] &&
                    i == (int'(last_grant) + k) % int'(NUM_REQ)) begin
                    grant_found = 1'b1;
                    grant_idx   = TAG_W'(i);
                    grant_oh[i] = 1'b1;
                    grant_data  = req_data[i*int'(N) +: N];
                end
            end
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = '0;
        take      = 1'b0;
        out_valid = rst_n && (state == OUT);
        busy      = rst_n && (state != IDLE);
        done      = out_valid && out_ready;
        case (state)
            IDLE: begin
                if (grant_found && armed && rst_n) begin
                    req_ready = grant_oh;
                    take      = 1'b1;
                    state_n   = CONV;
                end
            end
            CONV:    state_n = OUT;
            OUT:     if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // armed keeps the first cycle out of reset grant-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= TAG_W'(NUM_REQ - 1);
            armed      <= 1'b0;
            operand    <= '0;
            op_tag     <= '0;
            out_data   <= '0;
            out_tag    <= '0;
            conv_count <= '0;
        end else begin
            state <= state_n;
            armed <= 1'b1;
            if (take) begin
                last_grant <= grant_idx;
                operand    <= grant_data;
                op_tag     <= grant_idx;
            end
            if (state == CONV) begin
                out_data <= bcd_c;
                out_tag  <= op_tag;
            end
            if (done && conv_count != 16'hFFFF) begin
                conv_count <= conv_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter (N=8, NUM_REQ=4): transaction-level model checked every cycle
// plus directed scenarios with hand-computed results.
module tb_bcd_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic [1:0]  out_tag;
    logic        busy;
    logic [15:0] conv_count;

    int checks = 0;
    int errors = 0;

    bcd_conv_arbiter #(.N(8), .NUM_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy), .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits by plain division.
    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        int          x;
        r = '0;
        x = v;
        for (int d = 0; d < 3; d++) begin
            r = r | (12'(x % 10) << (4 * d));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int model_arb(input logic [3:0] v, input int lg);
        for (int k = 1; k <= 4; k++) begin
            if (v[(lg + k) % 4]) return (lg + k) % 4;
        end
        return -1;
    endfunction

    // Model state: at most one conversion in flight.
    int          cyc = 0;
    int          gcyc = 0;
    int          m_lg = 3;
    int          m_count = 0;
    bit          pending = 0;
    bit          post_rst = 0;
    logic [11:0] q_data = '0;
    logic [1:0]  q_tag = '0;
    logic [11:0] m_last = '0;
    logic [1:0]  m_last_tag = '0;

    always @(negedge clk) begin
        bit exp_ov;
        int exp_g;
        cyc++;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            pending    = 0;
            m_lg       = 3;
            m_count    = 0;
            m_last     = '0;
            m_last_tag = '0;
            post_rst   = 1;
        end else begin
            exp_ov = pending && (cyc >= gcyc + 2);
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("busy", 32'(busy), 32'(pending));
            chk("conv_count", 32'(conv_count), 32'(m_count));
            if (exp_ov) begin
                chk("out_data", 32'(out_data), 32'(q_data));
                chk("out_tag", 32'(out_tag), 32'(q_tag));
            end else begin
                chk("hold_data", 32'(out_data), 32'(m_last));
                chk("hold_tag", 32'(out_tag), 32'(m_last_tag));
            end
            if (post_rst || pending) begin
                chk("no_grant", 32'(req_ready), 32'd0);
            end else begin
                exp_g = model_arb(req_valid, m_lg);
                chk("grant", 32'(req_ready), (exp_g >= 0) ? (32'd1 << exp_g) : 32'd0);
                if (exp_g >= 0) begin
                    pending = 1;
                    gcyc    = cyc;
                    q_data  = ref_bcd(int'(req_data[exp_g*8 +: 8]));
                    q_tag   = 2'(exp_g);
                    m_lg    = exp_g;
                end
            end
            if (exp_ov && out_ready) begin
                pending    = 0;
                m_count    = (m_count == 65535) ? 65535 : m_count + 1;
                m_last     = q_data;
                m_last_tag = q_tag;
            end
            post_rst = 0;
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(output int g);
        bit seen = 0;
        g = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                seen = 1;
                for (int b = 0; b < 4; b++) if (req_ready[b]) g = b;
            end
        end
        chk("grant_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_out(output logic [11:0] d, output logic [1:0] tg);
        bit seen = 0;
        d  = '0;
        tg = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                d    = out_data;
                tg   = out_tag;
            end
        end
        chk("out_timeout", 32'(seen), 32'd1);
    endtask

    task automatic run_one(input int r, input logic [7:0] v, output logic [11:0] d, output logic [1:0] tg);
        int g;
        req_data[r*8 +: 8] = v;
        req_valid          = 4'(1 << r);
        out_ready          = 1'b1;
        wait_grant(g);
        @(posedge clk); #1;
        req_valid = '0;
        wait_out(d, tg);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [11:0] d;
        logic [11:0] d0;
        logic [1:0]  tg;
        logic [1:0]  t0;
        logic [15:0] c0;
        int          g;
        int          cnt [4];

        do_reset();

        // Single request: 255 -> 0x255 on tag 0.
        run_one(0, 8'd255, d, tg);
        chk("t1_data", 32'(d), 32'h255);
        chk("t1_tag", 32'(tg), 32'd0);
        @(negedge clk);
        chk("t1_count", 32'(conv_count), 32'd1);
        @(posedge clk); #1;

        // Every 8-bit operand through requester 1.
        for (int v = 0; v < 256; v++) begin
            run_one(1, 8'(v), d, tg);
            chk("ex_tag", 32'(tg), 32'd1);
            for (int n = 0; n < 3; n++) chk("ex_nibble_le9", 32'(d[n*4 +: 4] > 4'd9), 32'd0);
            if (v == 0)   chk("ex_0", 32'(d), 32'h000);
            if (v == 99)  chk("ex_99", 32'(d), 32'h099);
            if (v == 100) chk("ex_100", 32'(d), 32'h100);
        end

        // Two requesters held continuously alternate.
        do_reset();
        req_data[7:0]   = 8'd7;
        req_data[23:16] = 8'd200;
        req_valid       = 4'b0101;
        out_ready       = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_grant(g);
            chk("alt_grant", 32'(g), (n % 2 == 0) ? 32'd0 : 32'd2);
            wait_out(d, tg);
            chk("alt_data", 32'(d), (n % 2 == 0) ? 32'h007 : 32'h200);
            chk("alt_tag", 32'(tg), (n % 2 == 0) ? 32'd0 : 32'd2);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;

        // Stall in OUT for 10 cycles with all requesters pending.
        req_data[31:24] = 8'd42;
        req_valid       = 4'b1000;
        out_ready       = 1'b0;
        wait_grant(g);
        chk("stall_grant", 32'(g), 32'd3);
        @(posedge clk); #1;
        req_valid = 4'hF;
        wait_out(d0, t0);
        c0 = conv_count;
        chk("stall_data", 32'(d0), 32'h042);
        chk("stall_tag", 32'(t0), 32'd3);
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_data", 32'(out_data), 32'(d0));
            chk("stall_hold_tag", 32'(out_tag), 32'(t0));
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_count", 32'(conv_count), 32'(c0) + 32'd1);
        chk("stall_done", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Reset while in CONV discards the conversion.
        req_data[7:0] = 8'd5;
        req_valid     = 4'b0001;
        wait_grant(g);
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rc_valid", 32'(out_valid), 32'd0);
        chk("rc_count", 32'(conv_count), 32'd0);
        chk("rc_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        run_one(2, 8'd77, d, tg);
        chk("rc_data", 32'(d), 32'h077);
        chk("rc_tag", 32'(tg), 32'd2);
        @(negedge clk);
        chk("rc_count2", 32'(conv_count), 32'd1);
        @(posedge clk); #1;

        // All requesters busy: fair share over 16 conversions.
        do_reset();
        req_data  = 32'hC8_63_0A_01;
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) cnt[b] = 0;
        for (int n = 0; n < 16; n++) begin
            wait_grant(g);
            if (g >= 0) cnt[g]++;
            wait_out(d, tg);
        end
        @(posedge clk); #1;
        req_valid = '0;
        for (int b = 0; b < 4; b++) chk("fair_count", 32'(cnt[b]), 32'd4);
        @(negedge clk);
        chk("fair_conv_count", 32'(conv_count), 32'd16);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 Parameter N, default 8: binary operand width in bits; legal range 4..20.
REQ-002 Parameter NUM_REQ, default 4: number of requesters; legal range 2..8.
REQ-003 Derived constant BCD_W = 4*ceil(log10(2^N)) (12 for N=8); derived constant TAG_W = max(1, ceil(log2(NUM_REQ))).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 req_valid  input  NUM_REQ  bit i: requester i presents an operand.
REQ-007 req_data  input  NUM_REQ*N  operand of requester i in bits [i*N +: N].
REQ-008 req_ready  output  NUM_REQ  one-hot or zero; bit i: operand i accepted this cycle.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_data  output  BCD_W  packed BCD result; digit 0 (least significant) in bits [3:0].
REQ-012 out_tag  output  TAG_W  index of the requester that owns out_data.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 conv_count  output  16  number of completed output handshakes; saturates at 0xFFFF.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CONV, and OUT.
REQ-016 IDLE: if any req_valid bit is set, grant exactly one requester g, drive req_ready[g]=1 combinationally in that cycle, latch req_data[g] and g, and go to CONV; otherwise stay in IDLE.
REQ-017 req_ready SHALL be all-zero in CONV and OUT, and in IDLE when no req_valid bit is set.
REQ-018 Arbitration SHALL be round-robin: search order starts at (last_grant+1) mod NUM_REQ and wraps; last_grant updates only on a grant.
REQ-019 CONV: compute the shift-add-3 (double-dabble) conversion of the latched operand combinationally, register it into out_data, and go to OUT; the state lasts exactly one cycle.
REQ-020 OUT: out_valid=1 with out_data and out_tag held stable until out_ready=1; on out_valid and out_ready both high, increment conv_count and go to IDLE.
REQ-021 Latency: grant in cycle t gives out_valid=1 in cycle t+2 at the earliest.
REQ-022 Throughput: at most one conversion per 3 cycles; no grant in the cycle of an output handshake.
REQ-023 out_data SHALL equal the exact decimal value of the operand for all 2^N inputs; every nibble SHALL be in 0..9, and unused upper digits SHALL be 0.
REQ-024 out_valid=0 in IDLE and CONV; out_data and out_tag SHALL hold their last values outside OUT.
REQ-025 A requester that deasserts req_valid before it is granted loses its request without side effects; the block does not track pending requests.
REQ-026 If out_ready is held low, the block SHALL stall in OUT indefinitely with no grants.
REQ-027 Once conv_count reaches 0xFFFF it SHALL stay there until reset.

Reset
REQ-028 When rst_n=0 at a rising edge: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has top priority first), out_data=0, out_tag=0, conv_count=0.
REQ-029 During reset and in the first cycle after it, out_valid=0, busy=0, and req_ready=0.
REQ-030 Reset asserted in CONV or OUT SHALL discard the in-flight conversion; no output handshake occurs for it.
REQ-031 req_ready SHALL be forced to 0 while rst_n=0, regardless of req_valid.

Verification
REQ-032 After reset, req_valid=0001 with operand 8'd255 and out_ready=1 -> req_ready=0001 at t, out_valid at t+2 with out_data=12'h255 and out_tag=0, conv_count=1.
REQ-033 Exhaustive test, N=8: each operand 0..255 on requester 1 -> out_data equals its decimal BCD (0->12'h000, 99->12'h099, 100->12'h100), and no nibble exceeds 9.
REQ-034 After reset, req_valid=0101 held continuously with operands 8'd7 and 8'd200 -> grants in the order 0, 2, 0, 2; results 12'h007/tag 0 and 12'h200/tag 2 alternate.
REQ-035 out_ready=0 for 10 cycles in OUT -> out_valid, out_data, and out_tag are stable; req_ready=0 throughout; on out_ready=1, exactly one handshake and conv_count increments by 1.
REQ-036 rst_n pulsed low during CONV -> the next cycle is IDLE with out_valid=0 and conv_count=0; no result is emitted; a fresh request then completes normally.
REQ-037 All NUM_REQ requesters valid for 4*NUM_REQ conversions -> each requester is granted exactly 4 times.
